// File: rtl/and_req_arbiter.sv
// Round-robin arbiter that shares one registered bitwise-AND datapath among NUM_REQ requesters.
// Each accepted operand pair returns a & b, tagged with the requester index, on one valid/ready channel.
module and_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_W       = $clog2(NUM_REQ),
   parameter int CNT_W      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]               rsp_id,
   output logic                          busy,
   output logic [CNT_W-1:0]              txn_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       grant_idx;
   logic [ID_W-1:0]       cand;
   int unsigned           sum_idx;
   logic                  grant_found;
   logic                  accept;
   logic                  complete;
   logic [DATA_WIDTH-1:0] a_reg, b_reg;
   logic [ID_W-1:0]       id_reg;

   // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      cand        = rr_ptr;
      sum_idx     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sum_idx = 32'(rr_ptr) + k;
         if (sum_idx >= NUM_REQ) begin
            sum_idx = sum_idx - NUM_REQ;
         end
         cand = sum_idx[ID_W-1:0];
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (!reset && grant_found) begin
               req_ready[grant_idx] = 1'b1;
               accept               = 1'b1;
               state_nxt            = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         id_reg    <= '0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         txn_count <= '0;
      end else begin
         if (accept) begin
            a_reg  <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            b_reg  <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            id_reg <= grant_idx;
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
         end
         if (state == EXEC) begin
            rsp_data <= a_reg & b_reg;
            rsp_id   <= id_reg;
         end
         if (complete && (txn_count != '1)) begin
            txn_count <= txn_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_and_req_arbiter.sv
// Randomized and directed bench for and_req_arbiter: a predictor queues expected responses on acceptance,
// a negedge monitor compares every output each cycle; a narrow-counter instance covers saturation.
module tb_and_req_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready, req_ready_s;
   logic [N*W-1:0] req_a, req_b;
   logic           rsp_valid, rsp_valid_s;
   logic           rsp_ready;
   logic [W-1:0]   rsp_data, rsp_data_s;
   logic [1:0]     rsp_id, rsp_id_s;
   logic           busy, busy_s;
   logic [15:0]    txn_count;
   logic [1:0]     txn_count_s;

   and_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .txn_count(txn_count)
   );

   and_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .CNT_W(2)) dut_s (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_s), .rsp_id(rsp_id_s), .busy(busy_s), .txn_count(txn_count_s)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0] data;
      int           id;
      int           vis;
   } exp_t;

   exp_t q[$];
   exp_t m_pend;
   exp_t m_last;
   int   cyc = 0;
   bit   m_idle = 1'b1;
   int   m_ptr = 0;
   int   m_cnt = 0;
   int   n_chk = 0;
   int   n_bad = 0;

   // driver policy
   bit       auto_on = 1'b0;
   bit       auto_rst = 1'b0;
   int       rdy_mode = 2;
   int       p_valid = 0;
   int       p_drop = 0;
   logic [N-1:0] en = '1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic int grant_of(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (ptr + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   // Predictor: applies the arbitration rules at each rising edge using pre-edge inputs.
   initial forever begin : predictor
      int g;
      @(posedge clock);
      if (reset) begin
         m_idle = 1'b1;
         m_ptr  = 0;
         m_cnt  = 0;
         m_last = '{data: '0, id: 0, vis: 0};
      end else if (m_idle) begin
         g = grant_of(req_valid, m_ptr);
         if (g >= 0) begin
            m_pend = '{data: req_a[g*W +: W] & req_b[g*W +: W], id: g, vis: cyc + 2};
            q.push_back(m_pend);
            m_idle = 1'b0;
            m_ptr  = (g + 1) % N;
         end
      end else if (cyc >= m_pend.vis && rsp_ready) begin
         m_last = m_pend;
         m_cnt  = (m_cnt == 65535) ? 65535 : m_cnt + 1;
         m_idle = 1'b1;
      end
      cyc++;
   end

   // Monitor: compares every output against the model away from the active edge.
   initial forever begin : monitor
      int           g;
      bit           vis;
      logic [N-1:0] exp_rdy;
      logic [W-1:0] ed;
      int           eid;
      @(negedge clock);
      if (cyc > 0) begin
         g = grant_of(req_valid, m_ptr);
         exp_rdy = '0;
         if (!reset && m_idle && g >= 0) exp_rdy[g] = 1'b1;
         vis = (q.size() > 0) && (cyc >= q[0].vis);
         if (vis) begin
            ed  = q[0].data;
            eid = q[0].id;
         end else begin
            ed  = m_last.data;
            eid = m_last.id;
         end
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("busy", 32'(busy), 32'(!m_idle));
         chk("rsp_valid", 32'(rsp_valid), 32'(vis));
         chk("rsp_data", 32'(rsp_data), 32'(ed));
         chk("rsp_id", 32'(rsp_id), 32'(eid));
         chk("txn_count", 32'(txn_count), 32'(m_cnt));
         chk("sat_req_ready", 32'(req_ready_s), 32'(exp_rdy));
         chk("sat_busy", 32'(busy_s), 32'(!m_idle));
         chk("sat_rsp_valid", 32'(rsp_valid_s), 32'(vis));
         chk("sat_rsp_data", 32'(rsp_data_s), 32'(ed));
         chk("sat_rsp_id", 32'(rsp_id_s), 32'(eid));
         chk("sat_txn_count", 32'(txn_count_s), 32'((m_cnt > 3) ? 3 : m_cnt));
         if (reset) q.delete();
         else if (vis && rsp_ready) void'(q.pop_front());
      end
   end

   task automatic step();
      logic [N-1:0] hs;
      @(negedge clock);
      hs = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) req_valid[i] = 1'b0;
         if (auto_on) begin
            if (!en[i]) begin
               req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
               if ($urandom_range(99) < p_drop) req_valid[i] = 1'b0;
            end else if ($urandom_range(99) < p_valid) begin
               req_a[i*W +: W] = W'($urandom);
               req_b[i*W +: W] = W'($urandom);
               req_valid[i]    = 1'b1;
            end
         end
      end
      case (rdy_mode)
         0:       rsp_ready = ($urandom_range(99) < 70);
         1:       rsp_ready = 1'b1;
         default: rsp_ready = 1'b0;
      endcase
      if (auto_rst) reset = ($urandom_range(99) == 0);
   endtask

   task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_valid[id]    = 1'b1;
   endtask

   task automatic wait_rsp(input string nm, input int budget);
      int n;
      n = 0;
      while (!rsp_valid && n < budget) begin
         step();
         n++;
      end
      chk(nm, 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      // Reset while holding a response under backpressure; requests during reset are ignored.
      rdy_mode = 2;
      issue(1, 8'h55, 8'h0F);
      wait_rsp("t1_rsp", 10);
      repeat (2) step();
      reset = 1'b1;
      issue(0, 8'h12, 8'h34);
      issue(3, 8'hC3, 8'h5A);
      repeat (2) step();
      reset    = 1'b0;
      rdy_mode = 1;
      repeat (8) step();

      // Single request: 0xF0 & 0x3C from requester 2.
      issue(2, 8'hF0, 8'h3C);
      wait_rsp("t2_rsp", 10);
      chk("t2_data", 32'(rsp_data), 32'h30);
      chk("t2_id", 32'(rsp_id), 32'd2);
      repeat (3) step();

      // All requesters continuously valid.
      en = '1; p_valid = 100; p_drop = 0; auto_on = 1'b1;
      repeat (24) step();
      auto_on = 1'b0;
      repeat (15) step();

      // Backpressure for ten cycles.
      rdy_mode = 2;
      issue(1, 8'h9C, 8'hF5);
      wait_rsp("t4_rsp", 10);
      repeat (10) step();
      rdy_mode = 1;
      repeat (3) step();

      // Fairness skip with rr_ptr at 1 and only requesters 0 and 3 valid.
      issue(0, 8'h0F, 8'hFF);
      wait_rsp("t5_pre", 10);
      step();
      issue(0, 8'h81, 8'h18);
      issue(3, 8'h7E, 8'h3C);
      wait_rsp("t5_first", 10);
      chk("t5_first_id", 32'(rsp_id), 32'd3);
      step();
      wait_rsp("t5_second", 10);
      chk("t5_second_id", 32'(rsp_id), 32'd0);
      step();

      // Data vectors; narrow counter is saturated by now.
      issue(0, 8'hFF, 8'h00);
      wait_rsp("t6_a", 10);
      chk("t6_a_data", 32'(rsp_data), 32'h00);
      step();
      issue(2, 8'hAA, 8'hFF);
      wait_rsp("t6_b", 10);
      chk("t6_b_data", 32'(rsp_data), 32'hAA);
      step();

      // Single requester repeatedly valid.
      en = 4'b0100; p_valid = 100; auto_on = 1'b1;
      repeat (15) step();

      // Random traffic with drops, backpressure and occasional reset.
      en = '1; p_valid = 40; p_drop = 10; rdy_mode = 0; auto_rst = 1'b1;
      repeat (3000) step();
      auto_rst = 1'b0;
      reset    = 1'b0;
      auto_on  = 1'b0;
      rdy_mode = 1;
      repeat (20) step();
      chk("sb_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/and_req_arbiter.md
Name: and_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered bitwise-AND datapath among NUM_REQ requesters.
- Accepts one operand pair at a time over per-requester valid/ready, computes a & b, and returns the result tagged with the requester ID over a single valid/ready response channel.
- Sits between the stimulus-side request agents and the AND output interface; it is the sole owner of the AND resource.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, width of each operand and of the result.
- ID_W, $clog2(NUM_REQ), width of rsp_id; derived, not overridden.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A, flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_data  out  DATA_WIDTH  a & b of the granted request.
- rsp_id  out  ID_W  index of the requester that issued the request.
- busy  out  1  high in any state other than IDLE.
- txn_count  out  CNT_W  completed responses; saturates at all-ones.

Behaviour:
- Reset (synchronous, sampled on a rising edge with reset=1):
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, txn_count=0, busy=0.
  - req_ready=0 while reset is high.
  - Reset asserted in any state discards in-flight operands and results. No response is emitted for a discarded request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is combinational: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NUM_REQ-1 to 0.
  - req_ready[g]=1; all other req_ready bits are 0. All bits are 0 if no request is valid.
  - The grant is recomputed every IDLE cycle; there is no lock before the handshake.
  - On handshake (req_valid[g] & req_ready[g]) at edge T:
    - latch a_reg, b_reg and id_reg=g;
    - rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1;
    - state -> EXEC.
- EXEC:
  - req_ready=0.
  - rsp_data <= a_reg & b_reg; rsp_id <= id_reg; state -> RESP.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_data and rsp_id are held stable until accepted.
  - On rsp_valid & rsp_ready: txn_count += 1 (saturating); state -> IDLE; rsp_valid=0 from the next cycle.
- Latency:
  - Accept at edge T -> rsp_valid high in cycle T+2.
  - With rsp_ready tied high, the next accept is no earlier than edge T+3, i.e. one request per 3 cycles maximum.
- Requester obligations:
  - A requester holds req_valid and its operands stable until accepted.
  - Dropping req_valid before acceptance is tolerated; the arbiter simply re-arbitrates.
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0...
  - Single requester valid: it is granted on every opportunity regardless of rr_ptr.
  - rsp_ready low indefinitely: the FSM stays in RESP with outputs frozen, and no further request is accepted.
  - txn_count at 0xFFFF stays at 0xFFFF.
  - A request arriving on the same edge as reset release is not accepted; req_ready is 0 during reset.

Test Plan:
1. Reset while in RESP with rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, busy=0, txn_count=0, req_ready=0; after reset release, the first grant goes to requester 0 if it is valid.
2. Single request: requester 2 sends a=0xF0, b=0x3C, accepted at edge T -> at T+2 rsp_valid=1, rsp_data=0x30, rsp_id=2; with rsp_ready=1, txn_count=1.
3. All four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; each response is exactly 3 cycles apart.
4. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises -> rsp_data and rsp_id stable throughout, req_ready=0 throughout, busy=1; release gives exactly one completion.
5. Fairness skip: rr_ptr=1, only requesters 0 and 3 valid -> grant 3 first, then 0.
6. Saturation: force txn_count to 0xFFFE, complete 3 transactions -> txn_count reads 0xFFFF and stays there; data vectors a=0xFF/b=0x00 -> 0x00 and a=0xAA/b=0xFF -> 0xAA.
